// File: rtl/uart_rx_cfg_if.sv
// Purpose: bundles the receiver's tick/line/clear inputs and its held-frame outputs.
// Latency: none, this is wiring only.
// Backpressure: none here; rdy/rdy_clr form the consumer handshake and overrun flags a missed word.
// Ports: clken, rx, rdy_clr (towards receiver); rdy, data, parity_err, frame_err, brk, overrun (from receiver).
interface uart_rx_cfg_if #(
    parameter int DATA_BITS = 8
) ();
    logic                 clken;
    logic                 rx;
    logic                 rdy_clr;
    logic                 rdy;
    logic [DATA_BITS-1:0] data;
    logic                 parity_err;
    logic                 frame_err;
    logic                 brk;
    logic                 overrun;

    // master drives the line and consumes frames; slave is the receiver
    modport master (
        output clken, rx, rdy_clr,
        input  rdy, data, parity_err, frame_err, brk, overrun
    );
    modport slave (
        input  clken, rx, rdy_clr,
        output rdy, data, parity_err, frame_err, brk, overrun
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// Purpose: oversampling UART receiver, configurable data/parity/stop, majority-voted bits, break detect.
// Latency: rdy rises on the edge ending the clken tick at mid-point (+1) of the last stop bit.
// Backpressure: none; a commit while rdy is still set overwrites data and raises overrun.
// Ports: clk_50m, rst_n (sync, active-low); bus = uart_rx_cfg_if.slave (clken, rx, rdy_clr in;
//        rdy, data, parity_err, frame_err, brk, overrun out).
module uart_rx_cfg #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic         clk_50m,
    input  logic         rst_n,
    uart_rx_cfg_if.slave bus
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam int M  = OVERSAMPLE / 2;
    localparam logic [CW-1:0] CNT_M1   = CW'(M - 1);
    localparam logic [CW-1:0] CNT_M0   = CW'(M);
    localparam logic [CW-1:0] CNT_P1   = CW'(M + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic [DATA_BITS-1:0] scratch_q, scratch_d;
    logic                 rx_meta_q, rx_meta_d, rxs_q, rxs_d;
    logic                 s_m1_q, s_m1_d, s_m0_q, s_m0_d;
    logic                 par_pend_q, par_pend_d, frm_pend_q, frm_pend_d, brk_pend_q, brk_pend_d;
    logic                 zero_q, zero_d;     // every voted bit so far was 0
    logic                 armed_q, armed_d;   // line seen high in IDLE since the last break
    logic                 rdy_q, rdy_d, overrun_q, overrun_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 parity_err_q, parity_err_d, frame_err_q, frame_err_d, brk_q, brk_d;

    logic          vote, at_dec, wrap, par_exp, brk_now;
    logic [CW-1:0] cnt_nxt;

    always_comb begin
        vote    = (s_m1_q & s_m0_q) | (s_m1_q & rxs_q) | (s_m0_q & rxs_q);
        at_dec  = (cnt_q == CNT_P1);
        wrap    = (cnt_q == CNT_LAST);
        cnt_nxt = wrap ? '0 : cnt_q + 1'b1;
        par_exp = (^scratch_q) ^ (PARITY == 1);
        brk_now = (stop_idx_q == 1'b0) ? (zero_q & ~vote) : brk_pend_q;

        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        stop_idx_d   = stop_idx_q;
        scratch_d    = scratch_q;
        s_m1_d       = s_m1_q;
        s_m0_d       = s_m0_q;
        par_pend_d   = par_pend_q;
        frm_pend_d   = frm_pend_q;
        brk_pend_d   = brk_pend_q;
        zero_d       = zero_q;
        armed_d      = armed_q;
        rdy_d        = rdy_q;
        overrun_d    = overrun_q;
        data_d       = data_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        brk_d        = brk_q;

        // synchroniser runs every clock, independent of clken
        rx_meta_d = bus.rx;
        rxs_d     = rx_meta_q;

        if (bus.rdy_clr) begin
            rdy_d     = 1'b0;
            overrun_d = 1'b0;
        end

        if (bus.clken) begin
            if (cnt_q == CNT_M1) s_m1_d = rxs_q;
            if (cnt_q == CNT_M0) s_m0_d = rxs_q;

            case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    if (rxs_q) armed_d = 1'b1;
                    if (!rxs_q && armed_q) begin
                        state_d    = S_START;
                        cnt_d      = CW'(1);
                        bit_idx_d  = '0;
                        stop_idx_d = 1'b0;
                        zero_d     = 1'b1;
                        par_pend_d = 1'b0;
                        frm_pend_d = 1'b0;
                        brk_pend_d = 1'b0;
                    end
                end
                S_START: begin
                    cnt_d = cnt_nxt;
                    if (at_dec && vote) begin
                        // glitch shorter than half a bit: not a real start bit
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (wrap) begin
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    cnt_d = cnt_nxt;
                    if (at_dec) begin
                        scratch_d = {vote, scratch_q[DATA_BITS-1:1]};
                        if (vote) zero_d = 1'b0;
                    end
                    if (wrap) begin
                        if (bit_idx_q == BIT_LAST) begin
                            bit_idx_d = '0;
                            state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    cnt_d = cnt_nxt;
                    if (at_dec) begin
                        if (vote != par_exp) par_pend_d = 1'b1;
                        if (vote) zero_d = 1'b0;
                    end
                    if (wrap) state_d = S_STOP;
                end
                S_STOP: begin
                    cnt_d = cnt_nxt;
                    if (at_dec) begin
                        if (stop_idx_q == 1'b0) brk_pend_d = brk_now;
                        if (!vote) frm_pend_d = 1'b1;
                        if (stop_idx_q == STOP_LAST) begin
                            // commit mid-stop so the next start edge is caught early
                            data_d       = scratch_q;
                            parity_err_d = par_pend_q;
                            frame_err_d  = frm_pend_q | ~vote;
                            brk_d        = brk_now;
                            if (brk_now) armed_d = 1'b0;
                            // a commit beats a same-cycle clear; overrun then stays as it was
                            overrun_d = (rdy_q && !bus.rdy_clr) ? 1'b1 : overrun_q;
                            rdy_d     = 1'b1;
                            state_d   = S_IDLE;
                            cnt_d     = '0;
                        end
                    end
                    if (wrap && stop_idx_q != STOP_LAST) stop_idx_d = 1'b1;
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            stop_idx_q   <= 1'b0;
            scratch_q    <= '0;
            rx_meta_q    <= 1'b1;
            rxs_q        <= 1'b1;
            s_m1_q       <= 1'b1;
            s_m0_q       <= 1'b1;
            par_pend_q   <= 1'b0;
            frm_pend_q   <= 1'b0;
            brk_pend_q   <= 1'b0;
            zero_q       <= 1'b0;
            armed_q      <= 1'b0;
            rdy_q        <= 1'b0;
            overrun_q    <= 1'b0;
            data_q       <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            brk_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            stop_idx_q   <= stop_idx_d;
            scratch_q    <= scratch_d;
            rx_meta_q    <= rx_meta_d;
            rxs_q        <= rxs_d;
            s_m1_q       <= s_m1_d;
            s_m0_q       <= s_m0_d;
            par_pend_q   <= par_pend_d;
            frm_pend_q   <= frm_pend_d;
            brk_pend_q   <= brk_pend_d;
            zero_q       <= zero_d;
            armed_q      <= armed_d;
            rdy_q        <= rdy_d;
            overrun_q    <= overrun_d;
            data_q       <= data_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            brk_q        <= brk_d;
        end
    end

    assign bus.rdy        = rdy_q;
    assign bus.data       = data_q;
    assign bus.parity_err = parity_err_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.brk        = brk_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Purpose: directed checks of uart_rx_cfg in 8N1 (dut_a) and 8E1 (dut_b) configurations.
// Latency: frames are checked after the full stop bit has been driven.
// Backpressure: exercised through rdy_clr / overrun sequences.
module tb_uart_rx_cfg;
    localparam int OS = 16;

    logic clk_50m = 1'b0;
    logic rst_n   = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   rate    = 1;     // 0: clken held low, 1: every cycle, 2: every other cycle
    logic phase   = 1'b0;

    uart_rx_cfg_if #(.DATA_BITS(8)) bus_a ();
    uart_rx_cfg_if #(.DATA_BITS(8)) bus_b ();

    uart_rx_cfg #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(OS)) dut_a (
        .clk_50m (clk_50m),
        .rst_n   (rst_n),
        .bus     (bus_a.slave)
    );
    uart_rx_cfg #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(OS)) dut_b (
        .clk_50m (clk_50m),
        .rst_n   (rst_n),
        .bus     (bus_b.slave)
    );

    always #10 clk_50m = ~clk_50m;

    initial begin
        #4_000_000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int sel, input logic v);
        logic ce;
        @(posedge clk_50m);
        #1;
        phase = ~phase;
        if (rate == 0)      ce = 1'b0;
        else if (rate == 1) ce = 1'b1;
        else                ce = phase;
        bus_a.clken = ce;
        bus_b.clken = ce;
        if (sel == 0) bus_a.rx = v;
        else          bus_b.rx = v;
    endtask

    task automatic send_bit(input int sel, input logic v);
        int n;
        n = OS * ((rate == 2) ? 2 : 1);
        for (int i = 0; i < n; i++) step(sel, v);
    endtask

    task automatic idle(input int sel, input int nbits);
        for (int i = 0; i < nbits; i++) send_bit(sel, 1'b1);
    endtask

    task automatic send_frame(input int sel, input logic [7:0] d, input logic has_par,
                              input logic pbit, input logic stop);
        send_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(sel, d[i]);
        if (has_par) send_bit(sel, pbit);
        send_bit(sel, stop);
    endtask

    task automatic clr(input int sel);
        @(posedge clk_50m);
        #1;
        if (sel == 0) bus_a.rdy_clr = 1'b1; else bus_b.rdy_clr = 1'b1;
        @(posedge clk_50m);
        #1;
        bus_a.rdy_clr = 1'b0;
        bus_b.rdy_clr = 1'b0;
    endtask

    initial begin
        bus_a.rx = 1'b1; bus_a.clken = 1'b1; bus_a.rdy_clr = 1'b0;
        bus_b.rx = 1'b1; bus_b.clken = 1'b1; bus_b.rdy_clr = 1'b0;
        repeat (3) @(posedge clk_50m);
        #1 rst_n = 1'b1;

        @(negedge clk_50m);
        check("rst_rdy",  {31'd0, bus_a.rdy},        32'd0);
        check("rst_data", {24'd0, bus_a.data},       32'd0);
        check("rst_pe",   {31'd0, bus_a.parity_err}, 32'd0);
        check("rst_fe",   {31'd0, bus_a.frame_err},  32'd0);
        check("rst_brk",  {31'd0, bus_a.brk},        32'd0);
        check("rst_ov",   {31'd0, bus_a.overrun},    32'd0);
        check("rst_b_rdy",{31'd0, bus_b.rdy},        32'd0);

        // basic 8N1 frame
        idle(0, 2);
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
        idle(0, 1);
        @(negedge clk_50m);
        check("a5_rdy",  {31'd0, bus_a.rdy},        32'd1);
        check("a5_data", {24'd0, bus_a.data},       32'hA5);
        check("a5_pe",   {31'd0, bus_a.parity_err}, 32'd0);
        check("a5_fe",   {31'd0, bus_a.frame_err},  32'd0);
        check("a5_brk",  {31'd0, bus_a.brk},        32'd0);
        check("a5_ov",   {31'd0, bus_a.overrun},    32'd0);
        clr(0);
        @(negedge clk_50m);
        check("clr_rdy",  {31'd0, bus_a.rdy},  32'd0);
        check("clr_data", {24'd0, bus_a.data}, 32'hA5);

        // clken held low: the receiver must not advance
        rate = 0;
        send_frame(0, 8'h0F, 1'b0, 1'b0, 1'b1);
        rate = 1;
        idle(0, 2);
        @(negedge clk_50m);
        check("noce_rdy",  {31'd0, bus_a.rdy},  32'd0);
        check("noce_data", {24'd0, bus_a.data}, 32'hA5);

        // short glitch: false start, then a good frame
        for (int i = 0; i < 4; i++) step(0, 1'b0);
        idle(0, 3);
        @(negedge clk_50m);
        check("glitch_rdy", {31'd0, bus_a.rdy}, 32'd0);
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
        idle(0, 1);
        @(negedge clk_50m);
        check("3c_rdy",  {31'd0, bus_a.rdy},       32'd1);
        check("3c_data", {24'd0, bus_a.data},      32'h3C);
        check("3c_fe",   {31'd0, bus_a.frame_err}, 32'd0);
        clr(0);

        // half-rate clken
        rate = 2;
        send_frame(0, 8'hC3, 1'b0, 1'b0, 1'b1);
        idle(0, 1);
        rate = 1;
        @(negedge clk_50m);
        check("half_rdy",  {31'd0, bus_a.rdy},  32'd1);
        check("half_data", {24'd0, bus_a.data}, 32'hC3);
        clr(0);

        // even parity: 0x37 has five ones, so the correct parity bit is 1
        idle(1, 2);
        send_frame(1, 8'h37, 1'b1, 1'b0, 1'b1);
        idle(1, 1);
        @(negedge clk_50m);
        check("par_bad_rdy",  {31'd0, bus_b.rdy},        32'd1);
        check("par_bad_data", {24'd0, bus_b.data},       32'h37);
        check("par_bad_pe",   {31'd0, bus_b.parity_err}, 32'd1);
        check("par_bad_fe",   {31'd0, bus_b.frame_err},  32'd0);
        clr(1);
        send_frame(1, 8'h37, 1'b1, 1'b1, 1'b1);
        idle(1, 1);
        @(negedge clk_50m);
        check("par_ok_pe", {31'd0, bus_b.parity_err}, 32'd0);
        send_frame(1, 8'h03, 1'b1, 1'b0, 1'b1);
        idle(1, 1);
        @(negedge clk_50m);
        check("par_03_pe",   {31'd0, bus_b.parity_err}, 32'd0);
        check("par_03_data", {24'd0, bus_b.data},       32'h03);

        // stop bit low with nonzero data: framing error, not a break
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0);
        idle(0, 2);
        @(negedge clk_50m);
        check("fe_data", {24'd0, bus_a.data},      32'h55);
        check("fe_fe",   {31'd0, bus_a.frame_err}, 32'd1);
        check("fe_brk",  {31'd0, bus_a.brk},       32'd0);
        check("fe_ov",   {31'd0, bus_a.overrun},   32'd0);
        clr(0);

        // break: 0x00 with low stop, line held low three more frames
        send_frame(0, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) send_bit(0, 1'b0);
        @(negedge clk_50m);
        check("brk_rdy",  {31'd0, bus_a.rdy},       32'd1);
        check("brk_brk",  {31'd0, bus_a.brk},       32'd1);
        check("brk_fe",   {31'd0, bus_a.frame_err}, 32'd1);
        check("brk_data", {24'd0, bus_a.data},      32'h00);
        check("brk_ov",   {31'd0, bus_a.overrun},   32'd0);
        idle(0, 2);
        clr(0);
        send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1);
        idle(0, 1);
        @(negedge clk_50m);
        check("post_brk_data", {24'd0, bus_a.data},      32'h81);
        check("post_brk_brk",  {31'd0, bus_a.brk},       32'd0);
        check("post_brk_fe",   {31'd0, bus_a.frame_err}, 32'd0);
        clr(0);

        // overrun
        send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
        idle(0, 1);
        send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1);
        idle(0, 1);
        @(negedge clk_50m);
        check("ovr_rdy",  {31'd0, bus_a.rdy},     32'd1);
        check("ovr_data", {24'd0, bus_a.data},    32'h22);
        check("ovr_ov",   {31'd0, bus_a.overrun}, 32'd1);
        clr(0);
        @(negedge clk_50m);
        check("ovr_clr_rdy",  {31'd0, bus_a.rdy},     32'd0);
        check("ovr_clr_ov",   {31'd0, bus_a.overrun}, 32'd0);
        check("ovr_clr_data", {24'd0, bus_a.data},    32'h22);

        // reset during data bit 3 of 0x5A (bits 0..3 = 0,1,0,1)
        send_bit(0, 1'b0);
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        send_bit(0, 1'b0);
        for (int i = 0; i < OS / 2; i++) step(0, 1'b1);
        @(posedge clk_50m);
        #1;
        rst_n    = 1'b0;
        bus_a.rx = 1'b1;
        @(posedge clk_50m);
        #1;
        rst_n = 1'b1;
        @(negedge clk_50m);
        check("mid_rst_rdy",  {31'd0, bus_a.rdy},        32'd0);
        check("mid_rst_data", {24'd0, bus_a.data},       32'd0);
        check("mid_rst_fe",   {31'd0, bus_a.frame_err},  32'd0);
        check("mid_rst_ov",   {31'd0, bus_a.overrun},    32'd0);
        check("mid_rst_b",    {24'd0, bus_b.data},       32'd0);
        idle(0, 12);
        @(negedge clk_50m);
        check("mid_rst_norx", {31'd0, bus_a.rdy}, 32'd0);
        send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
        idle(0, 1);
        @(negedge clk_50m);
        check("5a_rdy",  {31'd0, bus_a.rdy},       32'd1);
        check("5a_data", {24'd0, bus_a.data},      32'h5A);
        check("5a_fe",   {31'd0, bus_a.frame_err}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame, legal range 5..9.
REQ-002 Parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-003 Parameter STOP_BITS, default 1, stop bits expected: 1 or 2.
REQ-004 Parameter OVERSAMPLE, default 16, clken ticks per bit, even, legal range 8..64.
REQ-005 clk_50m  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset, synchronous and active-low.
REQ-007 clken  input  1  oversample tick enable; FSM and counters advance only when high.
REQ-008 rx  input  1  asynchronous serial line, idle high.
REQ-009 rdy_clr  input  1  clears rdy and overrun.
REQ-010 rdy  output  1  a received frame is held in data.
REQ-011 data  output  DATA_BITS  last received word, LSB first on the wire.
REQ-012 parity_err  output  1  parity mismatch in the held frame; always 0 when PARITY=0.
REQ-013 frame_err  output  1  at least one stop bit sampled low in the held frame.
REQ-014 brk  output  1  break: all data bits, parity bit (if present) and first stop bit sampled low.
REQ-015 overrun  output  1  a frame was committed while rdy was still set.

Function
REQ-016 rx SHALL pass through a 2-flop synchroniser clocked every clk_50m cycle, independent of clken; all further logic SHALL use the synchronised value rxs.
REQ-017 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; encodings not listed SHALL return to IDLE on the next clken.
REQ-018 Sample counter width SHALL be clog2(OVERSAMPLE); it SHALL count 0..OVERSAMPLE-1 per bit and wrap to 0; define M = OVERSAMPLE/2.
REQ-019 Each bit value SHALL be the majority of rxs at counter values M-1, M and M+1; the decision SHALL be taken at count M+1.
REQ-020 IDLE: on clken with rxs=0, go to START with the counter set to 1; otherwise remain in IDLE with the counter held at 0.
REQ-021 START: if the voted start bit is 1 (false start, glitch), return to IDLE at count M+1; otherwise advance to DATA when the counter wraps.
REQ-022 DATA: shift voted bits LSB-first into a scratch register of DATA_BITS bits; after bit DATA_BITS-1 wraps, go to PARITY if PARITY!=0, else to STOP.
REQ-023 PARITY: compute the expected bit as XOR of the scratch bits, inverted for odd mode; a mismatch sets a pending parity flag; go to STOP on wrap.
REQ-024 STOP: vote each stop bit; a 0 on any stop bit sets a pending frame flag; the commit SHALL occur at count M+1 of the last stop bit, followed by IDLE on the same clken (mid-stop resynchronisation).
REQ-025 Commit SHALL load data, parity_err, frame_err and brk from scratch/pending flags and set rdy=1; if rdy=1 and rdy_clr=0 in the commit cycle, overrun SHALL be set to 1.
REQ-026 rdy_clr=1 without a commit SHALL clear rdy and overrun the next edge; a commit in the same cycle SHALL win (rdy=1, overrun unchanged).
REQ-027 data and the error flags SHALL hold until the next commit; rdy_clr SHALL NOT clear them.
REQ-028 A line held low after a break SHALL NOT start a new frame until rxs has been seen high in IDLE at least once.
REQ-029 Latency: rdy SHALL rise on the clk_50m edge ending the clken cycle of the commit.

Reset
REQ-030 With rst_n=0 at a rising edge: state IDLE, counters 0, scratch 0, synchroniser flops 1, rdy 0, data 0, parity_err 0, frame_err 0, brk 0, overrun 0.
REQ-031 Reset SHALL take priority over clken and rdy_clr, and SHALL abort any frame in progress with no commit.

Verification
REQ-032 8N1, clken every cycle, send 0xA5 -> data=0xA5, rdy=1, all error flags 0.
REQ-033 PARITY=2, send 0x37 with parity bit 0 (correct value is 1) -> data=0x37, parity_err=1, frame_err=0.
REQ-034 rx low for 4 clken ticks, then high -> FSM returns to IDLE, rdy stays 0.
REQ-035 Send 0x00 with stop bit low, then hold the line low for 3 frame times -> brk=1, frame_err=1, one commit only.
REQ-036 Send 0x11 then 0x22 with no rdy_clr -> data=0x22, overrun=1; then rdy_clr pulse -> rdy=0, overrun=0, data=0x22.
REQ-037 rst_n low for 1 cycle in DATA bit 3 -> all outputs at reset values; the next full frame 0x5A is received correctly.
